// File: rtl/mem_port_arbiter.sv
// Shares one single-port SRAM between instruction fetch and load/store.
// One owner per transaction, fixed memory latency, registered rdata and one-cycle acks.
module mem_port_arbiter #(
    parameter int MEM_LAT    = 1,
    parameter int STARVE_MAX = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        if_req,
    input  logic [31:0] if_addr,
    output logic        if_ack,
    output logic [31:0] if_rdata,
    output logic        pc_en,
    input  logic        d_req,
    input  logic        d_we,
    input  logic [31:0] d_addr,
    input  logic [31:0] d_wdata,
    output logic        d_ack,
    output logic [31:0] d_rdata,
    output logic        mem_cs,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata,
    output logic        busy
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        DONE   = 2'd2
    } state_t;

    localparam logic [3:0] LAT_INIT   = 4'(MEM_LAT);
    localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);

    state_t      state_r;
    logic        owner_fetch_r;
    logic [3:0]  lat_cnt_r;
    logic [3:0]  starve_r;
    logic        mem_cs_r;
    logic        mem_we_r;
    logic [31:0] mem_addr_r;
    logic [31:0] mem_wdata_r;
    logic [31:0] if_rdata_r;
    logic [31:0] d_rdata_r;
    logic        if_ack_r;
    logic        d_ack_r;
    logic        busy_r;
    logic        grant_fetch_s;
    logic        unused_s;

    // Word addressing: the byte-offset bits never reach the SRAM.
    assign unused_s = ^{if_addr[1:0], d_addr[1:0]};

    function automatic logic [3:0] starve_inc(input logic [3:0] cnt);
        if (cnt >= STARVE_LIM) begin
            return STARVE_LIM;
        end else begin
            return cnt + 4'd1;
        end
    endfunction

    // Arbitration: data wins unless fetch is alone or has waited STARVE_MAX data grants.
    always_comb begin
        grant_fetch_s = 1'b0;
        if (if_req && (!d_req || (starve_r == STARVE_LIM))) begin
            grant_fetch_s = 1'b1;
        end else begin
            grant_fetch_s = 1'b0;
        end
    end

    // Transaction sequencer with all port outputs held in registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r       <= IDLE;
            owner_fetch_r <= 1'b0;
            lat_cnt_r     <= 4'd0;
            starve_r      <= 4'd0;
            mem_cs_r      <= 1'b0;
            mem_we_r      <= 1'b0;
            mem_addr_r    <= 32'd0;
            mem_wdata_r   <= 32'd0;
            if_rdata_r    <= 32'd0;
            d_rdata_r     <= 32'd0;
            if_ack_r      <= 1'b0;
            d_ack_r       <= 1'b0;
            busy_r        <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    if_ack_r <= 1'b0;
                    d_ack_r  <= 1'b0;
                    if (if_req || d_req) begin
                        state_r       <= ACCESS;
                        busy_r        <= 1'b1;
                        mem_cs_r      <= 1'b1;
                        lat_cnt_r     <= LAT_INIT;
                        owner_fetch_r <= grant_fetch_s;
                        if (grant_fetch_s) begin
                            mem_addr_r  <= {if_addr[31:2], 2'b00};
                            mem_we_r    <= 1'b0;
                            mem_wdata_r <= 32'd0;
                            starve_r    <= 4'd0;
                        end else begin
                            mem_addr_r  <= {d_addr[31:2], 2'b00};
                            mem_we_r    <= d_we;
                            mem_wdata_r <= d_wdata;
                            starve_r    <= if_req ? starve_inc(starve_r) : starve_r;
                        end
                    end else begin
                        busy_r <= 1'b0;
                    end
                end
                ACCESS: begin
                    lat_cnt_r <= lat_cnt_r - 4'd1;
                    if (lat_cnt_r == 4'd1) begin
                        state_r     <= DONE;
                        mem_cs_r    <= 1'b0;
                        mem_we_r    <= 1'b0;
                        mem_addr_r  <= 32'd0;
                        mem_wdata_r <= 32'd0;
                        if (owner_fetch_r) begin
                            if_rdata_r <= mem_rdata;
                            if_ack_r   <= 1'b1;
                        end else begin
                            d_ack_r <= 1'b1;
                            // Stores leave the load data register untouched.
                            if (!mem_we_r) begin
                                d_rdata_r <= mem_rdata;
                            end
                        end
                    end
                end
                DONE: begin
                    if_ack_r <= 1'b0;
                    d_ack_r  <= 1'b0;
                    busy_r   <= 1'b0;
                    state_r  <= IDLE;
                end
                default: begin
                    state_r  <= IDLE;
                    mem_cs_r <= 1'b0;
                    mem_we_r <= 1'b0;
                    if_ack_r <= 1'b0;
                    d_ack_r  <= 1'b0;
                    busy_r   <= 1'b0;
                end
            endcase
        end
    end

    assign if_ack    = if_ack_r;
    assign pc_en     = if_ack_r;
    assign if_rdata  = if_rdata_r;
    assign d_ack     = d_ack_r;
    assign d_rdata   = d_rdata_r;
    assign mem_cs    = mem_cs_r;
    assign mem_we    = mem_we_r;
    assign mem_addr  = mem_addr_r;
    assign mem_wdata = mem_wdata_r;
    assign busy      = busy_r;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench: instance a uses MEM_LAT=1/STARVE_MAX=2, instance b uses MEM_LAT=3/STARVE_MAX=4.
module tb_mem_port_arbiter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        if_req, d_req, d_we;
    logic [31:0] if_addr, d_addr, d_wdata;

    logic        a_if_ack, a_pc_en, a_d_ack, a_mem_cs, a_mem_we, a_busy;
    logic [31:0] a_if_rdata, a_d_rdata, a_mem_addr, a_mem_wdata, a_mem_rdata;
    logic        b_if_ack, b_pc_en, b_d_ack, b_mem_cs, b_mem_we, b_busy;
    logic [31:0] b_if_rdata, b_d_rdata, b_mem_addr, b_mem_wdata, b_mem_rdata;

    int pass_cnt = 0;
    int total_cnt = 0;

    always #5 clk = ~clk;

    function automatic logic [31:0] mem_model(input logic [31:0] a);
        if (a == 32'h0040_0020) return 32'h8C22_0004;
        return ~a;
    endfunction

    assign a_mem_rdata = mem_model(a_mem_addr);
    assign b_mem_rdata = mem_model(b_mem_addr);

    mem_port_arbiter #(.MEM_LAT(1), .STARVE_MAX(2)) dut_a (
        .clk(clk), .rst_n(rst_n), .if_req(if_req), .if_addr(if_addr),
        .if_ack(a_if_ack), .if_rdata(a_if_rdata), .pc_en(a_pc_en),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_ack(a_d_ack), .d_rdata(a_d_rdata), .mem_cs(a_mem_cs), .mem_we(a_mem_we),
        .mem_addr(a_mem_addr), .mem_wdata(a_mem_wdata), .mem_rdata(a_mem_rdata),
        .busy(a_busy)
    );

    mem_port_arbiter #(.MEM_LAT(3), .STARVE_MAX(4)) dut_b (
        .clk(clk), .rst_n(rst_n), .if_req(if_req), .if_addr(if_addr),
        .if_ack(b_if_ack), .if_rdata(b_if_rdata), .pc_en(b_pc_en),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_ack(b_d_ack), .d_rdata(b_d_rdata), .mem_cs(b_mem_cs), .mem_we(b_mem_we),
        .mem_addr(b_mem_addr), .mem_wdata(b_mem_wdata), .mem_rdata(b_mem_rdata),
        .busy(b_busy)
    );

    typedef struct {
        logic        if_req;
        logic [31:0] if_addr;
        logic        d_req;
        logic        d_we;
        logic [31:0] d_addr;
        logic [31:0] d_wdata;
        logic        busy;
        logic        mem_cs;
        logic        mem_we;
        logic [31:0] mem_addr;
        logic        if_ack;
        logic        d_ack;
        logic [31:0] if_rdata;
        logic [31:0] d_rdata;
    } vec_t;

    vec_t vecs[14];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total_cnt++;
        if (act === exp) begin
            pass_cnt++;
        end else begin
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic do_reset();
        if_req = 1'b0; d_req = 1'b0; d_we = 1'b0;
        if_addr = 32'd0; d_addr = 32'd0; d_wdata = 32'd0;
        @(posedge clk); #1;
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        logic        g[6];
        logic        exp_g[6];
        int          n;
        int          lat;
        int          we_cnt, ack_cnt, ifack_cnt, bad_we;
        logic        found;

        // Reset held with both requesters active, then data must win the first edge.
        rst_n = 1'b0;
        if_req = 1'b1; if_addr = 32'h0040_0000;
        d_req = 1'b1; d_we = 1'b0; d_addr = 32'h1001_0004; d_wdata = 32'd0;
        repeat (3) @(negedge clk);
        check("rst_busy", {31'd0, a_busy}, 32'd0);
        check("rst_cs", {31'd0, a_mem_cs}, 32'd0);
        check("rst_we", {31'd0, a_mem_we}, 32'd0);
        check("rst_addr", a_mem_addr, 32'd0);
        check("rst_wdata", a_mem_wdata, 32'd0);
        check("rst_if_ack", {31'd0, a_if_ack}, 32'd0);
        check("rst_pc_en", {31'd0, a_pc_en}, 32'd0);
        check("rst_d_ack", {31'd0, a_d_ack}, 32'd0);
        check("rst_if_rdata", a_if_rdata, 32'd0);
        check("rst_d_rdata", a_d_rdata, 32'd0);
        check("rst_b_busy", {31'd0, b_busy}, 32'd0);
        check("rst_b_cs", {31'd0, b_mem_cs}, 32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        check("first_grant_cs", {31'd0, a_mem_cs}, 32'd1);
        check("first_grant_addr", a_mem_addr, 32'h1001_0004);
        check("first_grant_b_cs", {31'd0, b_mem_cs}, 32'd1);

        // Starvation with STARVE_MAX=2: D, D, F, D, D, F.
        exp_g = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
        n = 0;
        for (int c = 0; c < 60 && n < 6; c++) begin
            if (a_mem_cs) begin
                g[n] = (a_mem_addr == 32'h0040_0000);
                n++;
            end
            @(negedge clk);
        end
        check("starve_grants_seen", n, 6);
        for (int i = 0; i < n; i++) begin
            check($sformatf("starve_grant%0d_fetch", i), {31'd0, g[i]}, {31'd0, exp_g[i]});
        end

        // Table: single fetch, contention, then a load whose request drops before ack.
        vecs[0]  = '{1'b1, 32'h0040_0020, 1'b0, 1'b0, 32'd0, 32'd0, 1'b0, 1'b0, 1'b0, 32'd0, 1'b0, 1'b0, 32'd0, 32'd0};
        vecs[1]  = '{1'b1, 32'h0040_0020, 1'b0, 1'b0, 32'd0, 32'd0, 1'b1, 1'b1, 1'b0, 32'h0040_0020, 1'b0, 1'b0, 32'd0, 32'd0};
        vecs[2]  = '{1'b0, 32'd0, 1'b0, 1'b0, 32'd0, 32'd0, 1'b1, 1'b0, 1'b0, 32'd0, 1'b1, 1'b0, 32'h8C22_0004, 32'd0};
        vecs[3]  = '{1'b0, 32'd0, 1'b0, 1'b0, 32'd0, 32'd0, 1'b0, 1'b0, 1'b0, 32'd0, 1'b0, 1'b0, 32'h8C22_0004, 32'd0};
        vecs[4]  = '{1'b1, 32'h0040_0024, 1'b1, 1'b0, 32'h1001_0003, 32'd0, 1'b0, 1'b0, 1'b0, 32'd0, 1'b0, 1'b0, 32'h8C22_0004, 32'd0};
        vecs[5]  = '{1'b1, 32'h0040_0024, 1'b1, 1'b0, 32'h1001_0003, 32'd0, 1'b1, 1'b1, 1'b0, 32'h1001_0000, 1'b0, 1'b0, 32'h8C22_0004, 32'd0};
        vecs[6]  = '{1'b1, 32'h0040_0024, 1'b0, 1'b0, 32'd0, 32'd0, 1'b1, 1'b0, 1'b0, 32'd0, 1'b0, 1'b1, 32'h8C22_0004, 32'hEFFE_FFFF};
        vecs[7]  = '{1'b1, 32'h0040_0024, 1'b0, 1'b0, 32'd0, 32'd0, 1'b0, 1'b0, 1'b0, 32'd0, 1'b0, 1'b0, 32'h8C22_0004, 32'hEFFE_FFFF};
        vecs[8]  = '{1'b1, 32'h0040_0024, 1'b0, 1'b0, 32'd0, 32'd0, 1'b1, 1'b1, 1'b0, 32'h0040_0024, 1'b0, 1'b0, 32'h8C22_0004, 32'hEFFE_FFFF};
        vecs[9]  = '{1'b0, 32'd0, 1'b0, 1'b0, 32'd0, 32'd0, 1'b1, 1'b0, 1'b0, 32'd0, 1'b1, 1'b0, 32'hFFBF_FFDB, 32'hEFFE_FFFF};
        vecs[10] = '{1'b0, 32'd0, 1'b1, 1'b0, 32'h1001_0010, 32'd0, 1'b0, 1'b0, 1'b0, 32'd0, 1'b0, 1'b0, 32'hFFBF_FFDB, 32'hEFFE_FFFF};
        vecs[11] = '{1'b0, 32'd0, 1'b0, 1'b0, 32'd0, 32'd0, 1'b1, 1'b1, 1'b0, 32'h1001_0010, 1'b0, 1'b0, 32'hFFBF_FFDB, 32'hEFFE_FFFF};
        vecs[12] = '{1'b0, 32'd0, 1'b0, 1'b0, 32'd0, 32'd0, 1'b1, 1'b0, 1'b0, 32'd0, 1'b0, 1'b1, 32'hFFBF_FFDB, 32'hEFFE_FFEF};
        vecs[13] = '{1'b0, 32'd0, 1'b0, 1'b0, 32'd0, 32'd0, 1'b0, 1'b0, 1'b0, 32'd0, 1'b0, 1'b0, 32'hFFBF_FFDB, 32'hEFFE_FFEF};

        do_reset();
        for (int i = 0; i < 14; i++) begin
            @(posedge clk); #1;
            if_req = vecs[i].if_req; if_addr = vecs[i].if_addr;
            d_req = vecs[i].d_req; d_we = vecs[i].d_we;
            d_addr = vecs[i].d_addr; d_wdata = vecs[i].d_wdata;
            @(negedge clk);
            check($sformatf("v%0d_busy", i), {31'd0, a_busy}, {31'd0, vecs[i].busy});
            check($sformatf("v%0d_mem_cs", i), {31'd0, a_mem_cs}, {31'd0, vecs[i].mem_cs});
            check($sformatf("v%0d_mem_we", i), {31'd0, a_mem_we}, {31'd0, vecs[i].mem_we});
            check($sformatf("v%0d_mem_addr", i), a_mem_addr, vecs[i].mem_addr);
            check($sformatf("v%0d_if_ack", i), {31'd0, a_if_ack}, {31'd0, vecs[i].if_ack});
            check($sformatf("v%0d_pc_en", i), {31'd0, a_pc_en}, {31'd0, vecs[i].if_ack});
            check($sformatf("v%0d_d_ack", i), {31'd0, a_d_ack}, {31'd0, vecs[i].d_ack});
            check($sformatf("v%0d_if_rdata", i), a_if_rdata, vecs[i].if_rdata);
            check($sformatf("v%0d_d_rdata", i), a_d_rdata, vecs[i].d_rdata);
        end

        // MEM_LAT=3 load: ack four cycles after the request cycle.
        do_reset();
        @(posedge clk); #1;
        d_req = 1'b1; d_we = 1'b0; d_addr = 32'h1001_0008;
        lat = 0; found = 1'b0;
        for (int c = 0; c < 20 && !found; c++) begin
            @(negedge clk);
            if (b_d_ack) begin
                found = 1'b1;
                d_req = 1'b0;
            end else begin
                lat++;
            end
        end
        check("load_ack_seen", {31'd0, found}, 32'd1);
        check("load_latency", lat, 4);
        check("load_d_rdata", b_d_rdata, 32'hEFFE_FFF7);
        @(negedge clk);

        // MEM_LAT=3 store: mem_we for exactly three cycles, one d_ack, d_rdata kept.
        @(posedge clk); #1;
        d_req = 1'b1; d_we = 1'b1; d_addr = 32'h1001_0008; d_wdata = 32'hDEAD_BEEF;
        we_cnt = 0; ack_cnt = 0; ifack_cnt = 0; bad_we = 0;
        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            if (b_mem_we) begin
                we_cnt++;
                if (b_mem_addr != 32'h1001_0008 || b_mem_wdata != 32'hDEAD_BEEF || !b_mem_cs) bad_we++;
            end
            if (b_if_ack) ifack_cnt++;
            if (b_d_ack) begin
                ack_cnt++;
                d_req = 1'b0;
                d_we = 1'b0;
            end
        end
        check("store_we_cycles", we_cnt, 3);
        check("store_bus_values", bad_we, 0);
        check("store_d_ack_pulses", ack_cnt, 1);
        check("store_if_ack_pulses", ifack_cnt, 0);
        check("store_d_rdata_kept", b_d_rdata, 32'hEFFE_FFF7);

        // Completed fetch, then a second fetch abandoned by reset mid-ACCESS.
        @(posedge clk); #1;
        if_req = 1'b1; if_addr = 32'h0040_0020;
        found = 1'b0;
        for (int c = 0; c < 20 && !found; c++) begin
            @(negedge clk);
            if (b_if_ack) begin
                found = 1'b1;
                if_req = 1'b0;
            end
        end
        check("fetch_b_ack_seen", {31'd0, found}, 32'd1);
        check("fetch_b_if_rdata", b_if_rdata, 32'h8C22_0004);
        @(negedge clk);
        @(posedge clk); #1;
        if_req = 1'b1; if_addr = 32'h0040_0040;
        @(posedge clk);
        @(posedge clk); #1;
        check("abort_in_access", {31'd0, b_mem_cs}, 32'd1);
        rst_n = 1'b0;
        if_req = 1'b0;
        #1;
        check("abort_cs", {31'd0, b_mem_cs}, 32'd0);
        check("abort_busy", {31'd0, b_busy}, 32'd0);
        check("abort_mem_addr", b_mem_addr, 32'd0);
        check("abort_if_rdata", b_if_rdata, 32'd0);
        ifack_cnt = 0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            if (b_if_ack) ifack_cnt++;
        end
        check("abort_no_if_ack", ifack_cnt, 0);
        check("abort_busy_after", {31'd0, b_busy}, 32'd0);
        check("abort_if_rdata_after", b_if_rdata, 32'd0);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Sequences the single-port instruction/data SRAM so that the fetch stage and the load/store stage share one memory port. Sits between `instruction_fetch` (PC register and sequencer) and the `sram` instance. It grants one requester per transaction and waits a fixed memory latency. It returns registered read data and pulses an acknowledge; the fetch PC advances only on that acknowledge.

## Interface

Reset: one clock; reset is asynchronous and active-low.

Parameters:
- `MEM_LAT`, 1: cycles the memory needs between first `mem_cs` cycle and valid `mem_rdata`; legal range 1–15.
- `STARVE_MAX`, 4: consecutive data grants allowed while a fetch is waiting; legal range 1–15.

Ports:
- `clk`  in  1  rising-edge clock
- `rst_n`  in  1  asynchronous active-low reset
- `if_req`  in  1  fetch request, held until `if_ack`
- `if_addr`  in  32  fetch byte address (PC)
- `if_ack`  out  1  one-cycle pulse: `if_rdata` valid
- `if_rdata`  out  32  registered instruction word
- `pc_en`  out  1  PC register load enable; identical to `if_ack`
- `d_req`  in  1  data request, held until `d_ack`
- `d_we`  in  1  1 = store, 0 = load
- `d_addr`  in  32  data byte address
- `d_wdata`  in  32  store data
- `d_ack`  out  1  one-cycle pulse: transaction complete, `d_rdata` valid for loads
- `d_rdata`  out  32  registered load data
- `mem_cs`  out  1  SRAM chip select
- `mem_we`  out  1  SRAM write enable
- `mem_addr`  out  32  SRAM address, bits [1:0] forced 0
- `mem_wdata`  out  32  SRAM write data
- `mem_rdata`  in  32  SRAM read data
- `busy`  out  1  high in any state but IDLE

## Operation

- States:
  - IDLE: arbitration.
  - ACCESS: memory cycles.
  - DONE: acknowledge.
- IDLE with no request:
  - Stay in IDLE.
  - All `mem_*` outputs are 0.
- IDLE with any request:
  - Pick the owner.
  - Latch address, `we` and wdata into owner registers. For a fetch, `we` is 0 and wdata is 0.
  - Load the latency counter with `MEM_LAT`.
  - Go to ACCESS.
- Arbitration:
  - Data wins by default.
  - Fetch wins when `if_req` is high and the starve counter equals `STARVE_MAX`.
  - Fetch wins when it is the only requester.
- Starve counter:
  - Increments on a data grant made while `if_req` is high.
  - Clears on any fetch grant.
  - Saturates at `STARVE_MAX`.
- ACCESS:
  - `mem_cs` is 1 and `mem_addr`/`mem_we`/`mem_wdata` are driven from the latched registers, stable for the whole state.
  - The counter decrements each cycle.
  - On the edge that ends the cycle where counter = 1, `mem_rdata` is captured into the owner's rdata register for loads and fetches, then go to DONE.
- Stores:
  - `mem_we` is 1 through all of ACCESS.
  - `d_rdata` is unchanged.
  - `d_ack` still pulses.
- DONE:
  - The owner's ack is 1 for exactly one cycle; `pc_en` = `if_ack`.
  - Return to IDLE.
  - The other requester's ack stays 0.
- Request handshake:
  - A request that drops before its ack is ignored; the latched transaction completes and its ack still pulses.
  - A request still high in the IDLE cycle after DONE is treated as a new transaction.
- `d_addr`/`if_addr` bits [1:0] are ignored, with no misalignment error.
- Rdata registers hold their value until overwritten by that requester's next read.

## Timing

- All outputs are registered or decoded from state/latched registers. There is no combinational path from any input to any output.
- Reset values: `if_ack`=`d_ack`=`pc_en`=`mem_cs`=`mem_we`=`busy`=0; `mem_addr`=`mem_wdata`=`if_rdata`=`d_rdata`=0; state IDLE; starve counter 0.
- Latency:
  - Request first seen high in cycle t gives the grant at edge t+1.
  - ACCESS covers cycles t+1 … t+MEM_LAT.
  - Ack is high in cycle t+MEM_LAT+1.
- Throughput: one transaction per MEM_LAT+2 cycles.
- Simultaneous `if_req` and `d_req` in IDLE are resolved by the starve rule, in the same cycle only.
- A request arriving during ACCESS/DONE waits; it is not sampled until IDLE.
- Reset asserted mid-ACCESS or in DONE:
  - All outputs clear immediately.
  - The transaction is abandoned with no ack.
  - The rdata registers clear.

## Test plan

- Reset: hold `rst_n`=0 with both requests high, then release → all outputs 0 while in reset. With `d_req` high, a grant to data on the first edge after release.
- Single fetch, `MEM_LAT`=1: `if_addr`=0x00400020 at cycle 0, memory returns 0x8C220004 → `mem_cs`=1 and `mem_addr`=0x00400020 in cycle 1. `if_ack`=`pc_en`=1 and `if_rdata`=0x8C220004 in cycle 2. `busy`=0 in cycle 3.
- Contention: `if_req`=`d_req`=1 at cycle 0, `d_addr`=0x10010003 → data served first with `mem_addr`=0x10010000. Fetch then starts in the IDLE cycle after `d_ack`.
- Starvation, `STARVE_MAX`=2: `d_req` and `if_req` held high continuously → grant order data, data, fetch, data, data, fetch.
- Store, `MEM_LAT`=3: `d_we`=1, `d_addr`=0x10010008, `d_wdata`=0xDEADBEEF → `mem_we`=1 for exactly 3 cycles. Then `d_ack` pulses once with `d_rdata` unchanged. `if_ack` stays 0 throughout.
- Reset mid-access, `MEM_LAT`=3: drop `rst_n` in the second ACCESS cycle of a fetch → no `if_ack`, `if_rdata`=0. After release with no requests, `busy`=0.
